// File: rtl/ysyx_23060111_bus_pkg.sv
// Shared definitions for the memory arbiter slice: FSM state encoding,
// requester (owner) encoding and default bus widths.
package ysyx_23060111_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_23060111_rr_arb2.sv
// Two-way combinational round-robin selector.
// Ports:
//   if_valid, ls_valid : request valids from IFU / LSU
//   last_grant         : owner of the most recently completed transaction
//   grant              : one-hot grant, bit 0 = IFU, bit 1 = LSU
module ysyx_23060111_rr_arb2
  import ysyx_23060111_bus_pkg::*;
(
  input  logic       if_valid,
  input  logic       ls_valid,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (if_valid && ls_valid) begin
      grant = (last_grant == OWN_IF) ? 2'b10 : 2'b01;
    end else if (ls_valid) begin
      grant = 2'b10;
    end else if (if_valid) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_23060111_mem_arbiter.sv
// Memory port arbiter between the IFU (read-only) and the LSU (read/write).
// One outstanding transaction at a time, round-robin grant on ties, and an
// error response when memory stays silent for TIMEOUT cycles in WAIT.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   if_req_* / if_addr            : IFU request; if_req_ready pulses on grant
//   if_resp_valid/rdata/err       : IFU response (same cycle as memory response)
//   ls_req_* / ls_addr/wen/wdata/wmask : LSU request
//   ls_resp_valid/rdata/err       : LSU response (rdata 0 for writes)
//   m_req_valid/ready, m_addr/wen/wdata/wmask : request channel to memory
//   m_resp_valid, m_rdata         : response channel from memory
module ysyx_23060111_mem_arbiter
  import ysyx_23060111_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  m_addr_d;
  logic               m_wen_d;
  logic [DATA_W-1:0]  m_wdata_d;
  logic [MASK_W-1:0]  m_wmask_d;
  logic [1:0]         grant;
  logic               done;
  logic               err;
  logic [DATA_W-1:0]  resp_data;

  ysyx_23060111_rr_arb2 u_rr_arb2 (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      cnt_q        <= '0;
      m_addr       <= '0;
      m_wen        <= 1'b0;
      m_wdata      <= '0;
      m_wmask      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_addr       <= m_addr_d;
      m_wen        <= m_wen_d;
      m_wdata      <= m_wdata_d;
      m_wmask      <= m_wmask_d;
    end
  end

  // Next state, grant handshake and response generation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_addr_d     = m_addr;
    m_wen_d      = m_wen;
    m_wdata_d    = m_wdata;
    m_wmask_d    = m_wmask;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    m_req_valid  = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst so no ready is shown while reset is held.
        if (!rst && grant != 2'b00) begin
          state_d = REQ;
          if (grant[1]) begin
            ls_req_ready = 1'b1;
            owner_d      = OWN_LS;
            m_addr_d     = ls_addr;
            m_wen_d      = ls_wen;
            m_wdata_d    = ls_wdata;
            m_wmask_d    = ls_wmask;
          end else begin
            if_req_ready = 1'b1;
            owner_d      = OWN_IF;
            m_addr_d     = if_addr;
            m_wen_d      = 1'b0;
            m_wdata_d    = '0;
            m_wmask_d    = '0;
          end
        end
      end
      REQ: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real response beats the timeout when both land together.
        if (m_resp_valid) begin
          done = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response routing; read data passes straight through from memory.
  assign resp_data     = (done && !err && !m_wen) ? m_rdata : '0;
  assign if_resp_valid = done && (owner_q == OWN_IF);
  assign ls_resp_valid = done && (owner_q == OWN_LS);
  assign if_resp_err   = err && (owner_q == OWN_IF);
  assign ls_resp_err   = err && (owner_q == OWN_LS);
  assign if_rdata      = if_resp_valid ? resp_data : '0;
  assign ls_rdata      = ls_resp_valid ? resp_data : '0;

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Self-checking bench for ysyx_23060111_mem_arbiter: a per-cycle memory and
// arbitration model feeding a response scoreboard, a vector table, and
// hand-written sequences for stalls, timeouts, spurious responses and reset.
module tb_ysyx_23060111_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wmask;
  logic        m_req_valid, m_req_ready, m_wen, m_resp_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  always #5 clk = ~clk;

  ysyx_23060111_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Memory behaviour for the current transaction (resp_lat < 0: never responds).
  int          ready_lat, resp_lat;
  logic [31:0] mem_rdata;
  bit          force_resp, auto_drop;

  // Model state.
  bit          in_req, in_wait, cur_own, exp_last;
  int          req_cnt, wait_cnt, req_cycles, last_gcyc;
  logic [31:0] x_addr, x_wdata;
  logic [3:0]  x_wmask;
  logic        x_wen;

  typedef struct { bit own; logic [31:0] rdata; bit err; int at; } exp_t;
  exp_t sb[$];
  typedef struct { bit own; logic [31:0] rdata; bit err; int at; } rsp_t;
  rsp_t log_q[$];

  typedef struct {
    bit iv; logic [31:0] ia;
    bit lv; logic [31:0] la; bit lw; logic [31:0] wd; logic [3:0] wm;
    int rl; int pl; logic [31:0] md;
    int n; bit own; logic [31:0] rd; bit err;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_req_ready", 64'(if_req_ready), 64'(0));
    chk("rst_ls_req_ready", 64'(ls_req_ready), 64'(0));
    chk("rst_if_resp_valid", 64'(if_resp_valid), 64'(0));
    chk("rst_ls_resp_valid", 64'(ls_resp_valid), 64'(0));
    chk("rst_if_resp_err", 64'(if_resp_err), 64'(0));
    chk("rst_ls_resp_err", 64'(ls_resp_err), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata), 64'(0));
    chk("rst_ls_rdata", 64'(ls_rdata), 64'(0));
    chk("rst_m_req_valid", 64'(m_req_valid), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_wen", 64'(m_wen), 64'(0));
    chk("rst_m_wdata", 64'(m_wdata), 64'(0));
    chk("rst_m_wmask", 64'(m_wmask), 64'(0));
  endtask

  // Assert reset asynchronously, check outputs, then release just after an edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    in_req = 0; in_wait = 0; exp_last = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive memory, check every output, advance the model.
  task automatic step();
    bit   gi, gl, hs, done;
    exp_t e;
    rsp_t r;
    @(negedge clk);
    m_req_ready  = in_req && (req_cnt == ready_lat);
    m_resp_valid = (force_resp && !in_wait) ||
                   (in_wait && resp_lat >= 0 && wait_cnt == resp_lat);
    m_rdata      = m_resp_valid ? mem_rdata : 32'hA5A5_5A5A;
    #1;
    gi = 0; gl = 0;
    if (!in_req && !in_wait) begin
      if (if_req_valid && ls_req_valid) begin
        gl = (exp_last == 1'b0);
        gi = !gl;
      end else begin
        gl = ls_req_valid;
        gi = if_req_valid;
      end
    end
    chk("if_req_ready", 64'(if_req_ready), 64'(gi));
    chk("ls_req_ready", 64'(ls_req_ready), 64'(gl));
    chk("m_req_valid", 64'(m_req_valid), 64'(in_req));
    if (in_req) begin
      req_cycles++;
      chk("m_addr", 64'(m_addr), 64'(x_addr));
      chk("m_wen", 64'(m_wen), 64'(x_wen));
      chk("m_wdata", 64'(m_wdata), 64'(x_wdata));
      chk("m_wmask", 64'(m_wmask), 64'(x_wmask));
    end
    done = in_wait && (m_resp_valid || wait_cnt == int'(TO));
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: response due with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.at));
        chk("if_resp_valid", 64'(if_resp_valid), 64'(!e.own));
        chk("ls_resp_valid", 64'(ls_resp_valid), 64'(e.own));
        if (e.own) begin
          chk("ls_rdata", 64'(ls_rdata), 64'(e.rdata));
          chk("ls_resp_err", 64'(ls_resp_err), 64'(e.err));
        end else begin
          chk("if_rdata", 64'(if_rdata), 64'(e.rdata));
          chk("if_resp_err", 64'(if_resp_err), 64'(e.err));
        end
      end
    end else begin
      chk("if_resp_valid_quiet", 64'(if_resp_valid), 64'(0));
      chk("ls_resp_valid_quiet", 64'(ls_resp_valid), 64'(0));
    end
    if (if_resp_valid || ls_resp_valid) begin
      r.own   = ls_resp_valid;
      r.rdata = ls_resp_valid ? ls_rdata : if_rdata;
      r.err   = ls_resp_valid ? ls_resp_err : if_resp_err;
      r.at    = cyc;
      log_q.push_back(r);
    end
    if (gi || gl) begin
      cur_own   = gl;
      last_gcyc = cyc;
      x_addr  = gl ? ls_addr : if_addr;
      x_wen   = gl ? ls_wen : 1'b0;
      x_wdata = gl ? ls_wdata : 32'h0;
      x_wmask = gl ? ls_wmask : 4'h0;
      e.own   = gl;
      e.err   = (resp_lat < 0) || (resp_lat > int'(TO));
      e.rdata = (e.err || x_wen) ? 32'h0 : mem_rdata;
      e.at    = cyc + 2 + ready_lat + (e.err ? int'(TO) : resp_lat);
      sb.push_back(e);
    end
    hs = in_req && m_req_ready;
    @(posedge clk);
    #1;
    if (gi || gl) begin
      in_req = 1; req_cnt = 0;
      if (auto_drop && gi) if_req_valid = 1'b0;
      if (auto_drop && gl) ls_req_valid = 1'b0;
    end else if (in_req) begin
      if (hs) begin in_req = 0; in_wait = 1; wait_cnt = 0; end
      else req_cnt++;
    end else if (in_wait) begin
      if (done) begin in_wait = 0; exp_last = cur_own; end
      else wait_cnt++;
    end
    cyc++;
  endtask

  // Step until all requests are served, bounded by max_cyc.
  task automatic run_idle(input int max_cyc);
    int n = 0;
    while ((in_req || in_wait || sb.size() != 0 || if_req_valid || ls_req_valid) && n < max_cyc) begin
      step();
      n++;
    end
    chk("run_idle_finished", 64'(in_req || in_wait || if_req_valid || ls_req_valid), 64'(0));
  endtask

  task automatic set_mem(input int rl, input int pl, input logic [31:0] md);
    ready_lat = rl; resp_lat = pl; mem_rdata = md;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
    m_req_ready = 0; m_resp_valid = 0; m_rdata = 0;
    force_resp = 0; auto_drop = 1; req_cycles = 0; last_gcyc = 0;
    set_mem(0, 0, 32'h0);
    #1;

    // Both requesters valid from reset: LSU first, then strict alternation.
    if_req_valid = 1; if_addr = 32'h8000_0000;
    ls_req_valid = 1; ls_addr = 32'h8000_0800; ls_wen = 0;
    apply_reset();
    auto_drop = 0;
    set_mem(0, 0, 32'h600D_0000);
    log_q.delete();
    n = 0;
    while (log_q.size() < 8 && n < 60) begin step(); n++; end
    if_req_valid = 0; ls_req_valid = 0; auto_drop = 1;
    run_idle(20);
    chk("alt_count", 64'(log_q.size()), 64'(8));
    for (int k = 0; k < 8 && k < log_q.size(); k++)
      chk("alt_owner", 64'(log_q[k].own), 64'((k % 2) == 0));

    // Vector table (last_grant = IFU after the alternation).
    vt[0] = '{1, 32'h8000_0000, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0000_0413, 1, 0, 32'h0000_0413, 0};
    vt[1] = '{1, 32'h8000_0004, 1, 32'h8000_0100, 0, 32'h0, 4'h0, 1, 2, 32'hCAFE_F00D, 2, 1, 32'hCAFE_F00D, 0};
    vt[2] = '{1, 32'h8000_0008, 1, 32'h8000_0200, 1, 32'h1122_3344, 4'hF, 0, 1, 32'h5566_7788, 2, 1, 32'h0, 0};
    vt[3] = '{0, 32'h0, 1, 32'h8000_0300, 0, 32'h0, 4'h0, 0, 4, 32'h1234_5678, 1, 1, 32'h1234_5678, 0};
    vt[4] = '{1, 32'h8000_000C, 1, 32'h8000_0400, 0, 32'h0, 4'h0, 2, 3, 32'h0BAD_CAFE, 2, 0, 32'h0BAD_CAFE, 0};
    vt[5] = '{1, 32'h8000_0010, 0, 32'h0, 0, 32'h0, 4'h0, 0, -1, 32'hFFFF_FFFF, 1, 0, 32'h0, 1};
    vt[6] = '{1, 32'h8000_0014, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0000_0013, 1, 0, 32'h0000_0013, 0};
    for (int i = 0; i < 7; i++) begin
      log_q.delete();
      set_mem(vt[i].rl, vt[i].pl, vt[i].md);
      if_addr = vt[i].ia; ls_addr = vt[i].la; ls_wen = vt[i].lw;
      ls_wdata = vt[i].wd; ls_wmask = vt[i].wm;
      if_req_valid = vt[i].iv; ls_req_valid = vt[i].lv;
      run_idle(40);
      chk($sformatf("vec%0d_nresp", i), 64'(log_q.size()), 64'(vt[i].n));
      if (log_q.size() > 0) begin
        chk($sformatf("vec%0d_owner", i), 64'(log_q[0].own), 64'(vt[i].own));
        chk($sformatf("vec%0d_rdata", i), 64'(log_q[0].rdata), 64'(vt[i].rd));
        chk($sformatf("vec%0d_err", i), 64'(log_q[0].err), 64'(vt[i].err));
      end
    end

    // LSU write with memory stalling the request for 5 cycles.
    log_q.delete();
    set_mem(5, 0, 32'hFFFF_FFFF);
    ls_addr = 32'h8000_1000; ls_wen = 1; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'b0011;
    ls_req_valid = 1;
    req_cycles = 0;
    run_idle(30);
    chk("stall_req_cycles", 64'(req_cycles), 64'(6));
    chk("stall_nresp", 64'(log_q.size()), 64'(1));
    if (log_q.size() > 0) chk("stall_ls_rdata", 64'(log_q[0].rdata), 64'(0));
    ls_wen = 0;

    // Timeout: 4 silent WAIT cycles, error pulse, then immediate new grant.
    log_q.delete();
    set_mem(0, -1, 32'h0);
    ls_addr = 32'h8000_2000; ls_req_valid = 1;
    run_idle(30);
    chk("to_nresp", 64'(log_q.size()), 64'(1));
    if (log_q.size() > 0) begin
      chk("to_latency", 64'(log_q[0].at - last_gcyc), 64'(6));
      chk("to_err", 64'(log_q[0].err), 64'(1));
      chk("to_owner", 64'(log_q[0].own), 64'(1));
      n = log_q[0].at;
      set_mem(0, 0, 32'h0000_0093);
      if_addr = 32'h8000_0020; if_req_valid = 1;
      run_idle(20);
      chk("to_next_grant_cycle", 64'(last_gcyc), 64'(n + 1));
    end

    // Spurious m_resp_valid in IDLE and during REQ is ignored.
    log_q.delete();
    force_resp = 1;
    set_mem(3, 2, 32'h7777_0001);
    step(); step();
    if_addr = 32'h8000_0030; if_req_valid = 1;
    run_idle(30);
    force_resp = 0;
    chk("spur_nresp", 64'(log_q.size()), 64'(1));
    if (log_q.size() > 0) chk("spur_rdata", 64'(log_q[0].rdata), 64'h7777_0001);

    // Reset mid-WAIT, then a stray response: nothing may reach a requester.
    log_q.delete();
    set_mem(0, -1, 32'h0);
    ls_addr = 32'h8000_3000; ls_req_valid = 1;
    repeat (4) step();
    #2;
    m_resp_valid = 1; m_rdata = 32'h5555_AAAA;
    apply_reset();
    set_mem(0, 0, 32'h5555_AAAA);
    force_resp = 1;
    repeat (3) step();
    force_resp = 0;
    chk("rst_stray_nresp", 64'(log_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
